// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, flag indices and helpers for the pipelined FP multiplier
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  localparam int FLG_NX   = 0;
  localparam int FLG_UDRF = 1;
  localparam int FLG_OVRF = 2;
  localparam int FLG_NV   = 3;

  // Quiet NaN with positive sign and only the fraction MSB set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int frc_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << frc_w;
    v = v | (64'd1 << (frc_w - 1));
    return v;
  endfunction

  function automatic fclass_e fclass(input logic exp_zero, input logic exp_ones,
                                     input logic frc_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frc_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_round.sv
// rtl/fp_round.sv - combinational rounding incrementer for a normalised fraction
module fp_round
  import fp_pkg::*;
#(
  parameter int FRC_W = 23
) (
  input  logic [FRC_W-1:0] frc_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  input  logic             sign_i,
  input  logic [2:0]       mode_i,
  output logic [FRC_W-1:0] frc_o,
  output logic             carry_o,
  output logic             inexact_o
);

  logic inc;

  always_comb begin
    inexact_o = g_i | r_i | s_i;
    case (rmode_e'(mode_i))
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_i & inexact_o;
      RM_RUP:  inc = !sign_i & inexact_o;
      RM_RMM:  inc = g_i;
      default: inc = g_i & (r_i | s_i | frc_i[0]);
    endcase
  end

  assign {carry_o, frc_o} = {1'b0, frc_i} + {{FRC_W{1'b0}}, inc};

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-754 multiplier with valid/ready, DAZ/FTZ and sticky flags
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+FRC_W:0] fp_X,
  input  logic [EXP_W+FRC_W:0] fp_Y,
  input  logic [2:0]           r_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+FRC_W:0] fp_Z,
  output logic                 ovrf,
  output logic                 udrf,
  output logic                 nv,
  output logic                 nx,
  output logic [3:0]           flags_sticky,
  input  logic                 clear_flags
);

  localparam int W  = 1 + EXP_W + FRC_W;
  localparam int PW = 2 * FRC_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EOVF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [63:0] NAN64 = canon_nan(EXP_W, FRC_W);

  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic load1, load2, load3;

  logic                 s1_sign_q, s1_sign_d;
  fclass_e              s1_cls_q, s1_cls_d;
  logic [2:0]           s1_mode_q, s1_mode_d;
  logic [PW-1:0]        s1_prod_q, s1_prod_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;

  logic                 s2_sign_q, s2_sign_d;
  fclass_e              s2_cls_q, s2_cls_d;
  logic [2:0]           s2_mode_q, s2_mode_d;
  logic [FRC_W-1:0]     s2_frc_q, s2_frc_d;
  logic                 s2_g_q, s2_g_d, s2_r_q, s2_r_d, s2_s_q, s2_s_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-2:0]        s2_shift;

  logic [W-1:0]         s3_z_q, s3_z_d;
  logic [3:0]           s3_flg_q, s3_flg_d;
  logic [3:0]           sticky_q, sticky_d;

  fclass_e              cx, cy;
  logic [FRC_W-1:0]     rnd_frc;
  logic                 rnd_carry, rnd_nx, ovf_max;
  logic signed [EW-1:0] e3;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign load3    = !v3_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  assign cx = fclass(fp_X[W-2:FRC_W] == '0, &fp_X[W-2:FRC_W], fp_X[FRC_W-1:0] == '0);
  assign cy = fclass(fp_Y[W-2:FRC_W] == '0, &fp_Y[W-2:FRC_W], fp_Y[FRC_W-1:0] == '0);

  always_comb begin
    s1_sign_d = s1_sign_q;
    s1_cls_d  = s1_cls_q;
    s1_mode_d = s1_mode_q;
    s1_prod_d = s1_prod_q;
    s1_exp_d  = s1_exp_q;
    if (load1 && in_valid) begin
      s1_sign_d = fp_X[W-1] ^ fp_Y[W-1];
      s1_mode_d = r_mode;
      s1_prod_d = PW'({1'b1, fp_X[FRC_W-1:0]}) * PW'({1'b1, fp_Y[FRC_W-1:0]});
      s1_exp_d  = $signed({2'b00, fp_X[W-2:FRC_W]}) + $signed({2'b00, fp_Y[W-2:FRC_W]}) - BIAS;
      if (cx == CLS_NAN || cy == CLS_NAN || (cx == CLS_INF && cy == CLS_ZERO) ||
          (cx == CLS_ZERO && cy == CLS_INF))
        s1_cls_d = CLS_NAN;
      else if (cx == CLS_INF || cy == CLS_INF)
        s1_cls_d = CLS_INF;
      else if (cx == CLS_ZERO || cy == CLS_ZERO)
        s1_cls_d = CLS_ZERO;
      else
        s1_cls_d = CLS_NORM;
    end
  end

  // Leading one lands on the dropped top bit; everything below the fraction is G, R, sticky.
  assign s2_shift = s1_prod_q[PW-1] ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};

  always_comb begin
    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_mode_d = s2_mode_q;
    s2_frc_d  = s2_frc_q;
    s2_g_d    = s2_g_q;
    s2_r_d    = s2_r_q;
    s2_s_d    = s2_s_q;
    s2_exp_d  = s2_exp_q;
    if (load2 && v1_q) begin
      s2_sign_d = s1_sign_q;
      s2_cls_d  = s1_cls_q;
      s2_mode_d = s1_mode_q;
      s2_frc_d  = s2_shift[PW-2 -: FRC_W];
      s2_g_d    = s2_shift[FRC_W];
      s2_r_d    = s2_shift[FRC_W-1];
      s2_s_d    = |s2_shift[FRC_W-2:0];
      s2_exp_d  = s1_exp_q + $signed({{(EW-1){1'b0}}, s1_prod_q[PW-1]});
    end
  end

  fp_round #(.FRC_W(FRC_W)) u_round (
    .frc_i    (s2_frc_q),
    .g_i      (s2_g_q),
    .r_i      (s2_r_q),
    .s_i      (s2_s_q),
    .sign_i   (s2_sign_q),
    .mode_i   (s2_mode_q),
    .frc_o    (rnd_frc),
    .carry_o  (rnd_carry),
    .inexact_o(rnd_nx)
  );

  assign e3      = s2_exp_q + $signed({{(EW-1){1'b0}}, rnd_carry});
  assign ovf_max = (s2_mode_q == RM_RTZ) || (s2_mode_q == RM_RDN && !s2_sign_q) ||
                   (s2_mode_q == RM_RUP && s2_sign_q);

  always_comb begin
    s3_z_d   = s3_z_q;
    s3_flg_d = s3_flg_q;
    if (load3 && v2_q) begin
      s3_flg_d = '0;
      case (s2_cls_q)
        CLS_NAN: begin
          s3_z_d           = NAN64[W-1:0];
          s3_flg_d[FLG_NV] = 1'b1;
        end
        CLS_INF:  s3_z_d = {s2_sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        CLS_ZERO: s3_z_d = {s2_sign_q, {(W-1){1'b0}}};
        default: begin
          if (e3 >= EOVF) begin
            s3_z_d = ovf_max ? {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}}
                             : {s2_sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            s3_flg_d[FLG_OVRF] = 1'b1;
            s3_flg_d[FLG_NX]   = 1'b1;
          end else if (e3 <= EZERO) begin
            s3_z_d             = {s2_sign_q, {(W-1){1'b0}}};
            s3_flg_d[FLG_UDRF] = 1'b1;
            s3_flg_d[FLG_NX]   = 1'b1;
          end else begin
            s3_z_d           = {s2_sign_q, e3[EXP_W-1:0], rnd_frc};
            s3_flg_d[FLG_NX] = rnd_nx;
          end
        end
      endcase
    end
  end

  always_comb begin
    v1_d = load1 ? in_valid : v1_q;
    v2_d = load2 ? v1_q : v2_q;
    v3_d = load3 ? v2_q : v3_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
    // Clear drops the old value only; the beat leaving this cycle is still recorded.
    sticky_d = clear_flags ? 4'b0000 : sticky_q;
    if (v3_q && out_ready) sticky_d = sticky_d | s3_flg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= CLS_ZERO;
      s1_mode_q <= '0;
      s1_prod_q <= '0;
      s1_exp_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_cls_q  <= CLS_ZERO;
      s2_mode_q <= '0;
      s2_frc_q  <= '0;
      s2_g_q    <= 1'b0;
      s2_r_q    <= 1'b0;
      s2_s_q    <= 1'b0;
      s2_exp_q  <= '0;
      s3_z_q    <= '0;
      s3_flg_q  <= '0;
      sticky_q  <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_sign_q <= s1_sign_d;
      s1_cls_q  <= s1_cls_d;
      s1_mode_q <= s1_mode_d;
      s1_prod_q <= s1_prod_d;
      s1_exp_q  <= s1_exp_d;
      s2_sign_q <= s2_sign_d;
      s2_cls_q  <= s2_cls_d;
      s2_mode_q <= s2_mode_d;
      s2_frc_q  <= s2_frc_d;
      s2_g_q    <= s2_g_d;
      s2_r_q    <= s2_r_d;
      s2_s_q    <= s2_s_d;
      s2_exp_q  <= s2_exp_d;
      s3_z_q    <= s3_z_d;
      s3_flg_q  <= s3_flg_d;
      sticky_q  <= sticky_d;
    end
  end

  assign out_valid    = v3_q;
  assign fp_Z         = s3_z_q;
  assign nv           = s3_flg_q[FLG_NV];
  assign ovrf         = s3_flg_q[FLG_OVRF];
  assign udrf         = s3_flg_q[FLG_UDRF];
  assign nx           = s3_flg_q[FLG_NX];
  assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed and randomized self-checking bench for fp_mul_pipe
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, clear_flags;
  logic        ovrf, udrf, nv, nx;
  logic [31:0] fp_X, fp_Y, fp_Z;
  logic [2:0]  r_mode;
  logic [3:0]  flags_sticky;

  int          n_pass = 0, n_fail = 0, n_total = 0, n_recv = 0;
  logic [35:0] exp_q[$];
  logic [3:0]  exp_sticky;
  logic        held_v;
  logic [31:0] held_z;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .fp_Z(fp_Z),
    .ovrf(ovrf), .udrf(udrf), .nv(nv), .nx(nx),
    .flags_sticky(flags_sticky), .clear_flags(clear_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: integer mantissa product, rounding decided from the remainder vs half-ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] m);
    int ex, ey, e, sh;
    logic s, xz, yz, xi, yi, xn, yn, inc;
    longint unsigned p, keep, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (xz && yi)) return {4'b1000, 32'h7fc00000};
    if (xi || yi) return {4'b0000, s, 8'hff, 23'd0};
    if (xz || yz) return {4'b0000, s, 31'd0};
    p = (64'(x[22:0]) + 64'd8388608) * (64'(y[22:0]) + 64'd8388608);
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    case (m)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (rem != 0);
      3'd3:    inc = !s && (rem != 0);
      3'd4:    inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && keep[0]);
    endcase
    keep = keep + 64'(inc);
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255)
      return {4'b0101, (m == 3'd1 || (m == 3'd2 && !s) || (m == 3'd3 && s)) ?
                       {s, 8'hfe, 23'h7fffff} : {s, 8'hff, 23'd0}};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, rem != 0, s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: begin
        e = 8'hff;
        if ($urandom_range(0, 1) == 1) f = '0;
      end
      2:       e = 8'($urandom_range(200, 254));
      3:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One cycle: inputs are already driven; sample before the edge, then advance to the next negedge.
  task automatic step(output logic acc);
    logic        hs_out;
    logic [35:0] e;
    #1;
    check("sticky", flags_sticky, exp_sticky);
    if (held_v) check("hold_z", {out_valid, fp_Z}, {1'b1, held_z});
    held_v = 1'b0;
    acc    = in_valid && in_ready && !flush;
    hs_out = out_valid && out_ready;
    if (clear_flags) exp_sticky = 4'b0000;
    if (hs_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        n_recv = n_recv + 1;
        check("z", fp_Z, e[31:0]);
        check("flags", {nv, ovrf, udrf, nx}, e[35:32]);
        exp_sticky = exp_sticky | e[35:32];
      end
    end
    if (out_valid && !out_ready && !flush) begin
      held_v = 1'b1;
      held_z = fp_Z;
    end
    if (flush) exp_q.delete();
    if (acc) exp_q.push_back(ref_mul(fp_X, fp_Y, r_mode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] m, input logic [31:0] ez, input logic [3:0] ef);
    int lat;
    fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat = lat + 1;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_z"}, fp_Z, ez);
    check({tag, "_flags"}, {nv, ovrf, udrf, nx}, ef);
    exp_sticky = exp_sticky | ef;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   sent, cyc;
    int   pat[4] = '{1, 0, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clear_flags = 1'b0;
    fp_X = '0; fp_Y = '0; r_mode = '0; exp_sticky = '0; held_v = 1'b0; held_z = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_z", fp_Z, 32'h0);
    check("rst_flags", {nv, ovrf, udrf, nx}, 4'b0000);
    check("rst_sticky", flags_sticky, 4'b0000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    single("mul3x3_rtz",   32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 4'b0000);
    single("lsb_rne",      32'h3f800001, 32'h3f800001, 3'd0, 32'h3f800002, 4'b0001);
    single("lsb_rtz",      32'h3f800001, 32'h3f800001, 3'd1, 32'h3f800002, 4'b0001);
    single("lsb_rdn",      32'h3f800001, 32'h3f800001, 3'd2, 32'h3f800002, 4'b0001);
    single("lsb_rup",      32'h3f800001, 32'h3f800001, 3'd3, 32'h3f800003, 4'b0001);
    single("tie_rne",      32'h3fc00000, 32'h3f800003, 3'd0, 32'h3fc00004, 4'b0001);
    single("tie_rmm",      32'h3fc00000, 32'h3f800003, 3'd4, 32'h3fc00005, 4'b0001);
    single("tie_mode5",    32'h3fc00000, 32'h3f800003, 3'd5, 32'h3fc00004, 4'b0001);
    single("ovf_rne",      32'h7f000000, 32'h7f000000, 3'd0, 32'h7f800000, 4'b0101);
    single("ovf_rtz",      32'h7f000000, 32'h7f000000, 3'd1, 32'h7f7fffff, 4'b0101);
    single("ovf_rdn_pos",  32'h7f000000, 32'h7f000000, 3'd2, 32'h7f7fffff, 4'b0101);
    single("ovf_rdn_neg",  32'hff000000, 32'h7f000000, 3'd2, 32'hff800000, 4'b0101);
    single("ovf_rup_neg",  32'hff000000, 32'h7f000000, 3'd3, 32'hff7fffff, 4'b0101);
    single("ovf_mode7",    32'h7f000000, 32'h7f000000, 3'd7, 32'h7f800000, 4'b0101);
    single("max_exp",      32'h7f000000, 32'h3fc00000, 3'd0, 32'h7f400000, 4'b0000);
    single("min_exp",      32'h20000000, 32'h20000000, 3'd0, 32'h00800000, 4'b0000);
    single("udf",          32'h20000000, 32'h1f800000, 3'd0, 32'h00000000, 4'b0011);
    single("daz",          32'h00400000, 32'h40000000, 3'd0, 32'h00000000, 4'b0000);
    single("neg_zero",     32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 4'b0000);
    single("inf_x_zero",   32'h80000000, 32'h7f800000, 3'd0, 32'h7fc00000, 4'b1000);
    single("nan_in",       32'hffc00001, 32'h3f800000, 3'd0, 32'h7fc00000, 4'b1000);
    single("inf_x_norm",   32'hff800000, 32'h40000000, 3'd0, 32'hff800000, 4'b0000);

    // Clear the accumulated flags with nothing in flight.
    in_valid = 1'b0; out_ready = 1'b1; clear_flags = 1'b1;
    step(acc);
    clear_flags = 1'b0;

    // Eight back-to-back beats with out_ready cycling 1,0,0,1.
    sent = 0; cyc = 0; n_recv = 0;
    fp_X = rnd_op(); fp_Y = rnd_op(); r_mode = 3'($urandom);
    while ((sent < 8 || exp_q.size() != 0) && cyc < 200) begin
      in_valid  = (sent < 8);
      out_ready = (pat[cyc % 4] == 1);
      step(acc);
      if (acc) begin
        sent = sent + 1;
        fp_X = rnd_op(); fp_Y = rnd_op(); r_mode = 3'($urandom);
      end
      cyc = cyc + 1;
    end
    check("pat_drain", exp_q.size(), 0);
    check("pat_count", n_recv, 8);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      clear_flags = ($urandom_range(0, 19) == 0);
      step(acc);
      if (acc) begin
        fp_X = rnd_op(); fp_Y = rnd_op(); r_mode = 3'($urandom);
      end
    end
    clear_flags = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(acc);
    check("rand_drain", exp_q.size(), 0);

    // Fill the pipeline, flush with a beat offered, expect nothing to emerge.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      if (acc) begin
        fp_X = rnd_op(); fp_Y = rnd_op();
      end
    end
    flush = 1'b1;
    step(acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      check("flush_no_out", out_valid, 1'b0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 24) == 0);
      step(acc);
      if (acc) begin
        fp_X = rnd_op(); fp_Y = rnd_op(); r_mode = 3'($urandom);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(acc);
    check("flush_drain", exp_q.size(), 0);

    // Make sure the sticky flags hold something, then reset mid-stream.
    single("pre_rst", 32'h7f000000, 32'h7f000000, 3'd0, 32'h7f800000, 4'b0101);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      if (acc) begin
        fp_X = rnd_op(); fp_Y = rnd_op();
      end
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sticky", flags_sticky, 4'b0000);
    check("mid_rst_z", fp_Z, 32'h0);
    check("mid_rst_flags", {nv, ovrf, udrf, nx}, 4'b0000);
    exp_q.delete();
    exp_sticky = '0;
    held_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    single("post_rst", 32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 4'b0000);
    out_ready = 1'b1;
    step(acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshaking, five rounding modes and sticky exception flags. It is the next-generation multiplier datapath for the FPU ALU. It supersedes the single-precision combinational multiplier with a 3-stage pipeline that sustains one operation per cycle and supports backpressure. Subnormal operands are flushed to zero, and underflowing results are flushed to signed zero.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- FRC_W, 23, stored fraction width; total width W = 1+EXP_W+FRC_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- fp_X, fp_Y  in  W  operands.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- flush  in  1  synchronous kill of all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- fp_Z  out  W  result.
- ovrf, udrf, nv, nx  out  1 each  per-result flags: overflow, underflow, invalid, inexact.
- flags_sticky  out  4  accumulated {nv,ovrf,udrf,nx} of every result accepted at the output.
- clear_flags  in  1  synchronous clear of flags_sticky.

## Operation
**Input classification.**
- Exponent 0 means zero; the fraction is ignored (DAZ).
- Exponent all-ones with fraction 0 means infinity.
- Exponent all-ones with fraction ≠ 0 means NaN.

**Result sign.**
- Result sign = sign_X ^ sign_Y for every result except NaN.

**Special cases.**
- NaN input, or inf×zero: canonical qNaN = sign 0, exponent all-ones, fraction MSB 1, rest 0 (0x7fc00000 at default width); nv=1.
- inf×(non-zero, non-NaN): signed infinity; no flags.
- zero×(non-inf, non-NaN): signed zero; no flags. udrf is not raised for DAZ inputs.

**Datapath.**
- Product = {1,frc_X}×{1,frc_Y}, 2·FRC_W+2 bits.
- If the product MSB is set, shift by 0 and add 1 to the exponent; otherwise shift left by 1.
- After normalisation, keep FRC_W fraction bits plus guard, round and sticky (OR of all remaining bits).

**Exponent.**
- Computed signed in EXP_W+2 bits: e = eX + eY − bias + norm + rcarry, with bias = 2^(EXP_W−1)−1.
- rcarry is set when rounding overflows the fraction; the fraction then becomes 0.

**Rounding.**
- RNE: increment if G & (R|S|LSB).
- RTZ: never increment.
- RDN: increment if sign & (G|R|S).
- RUP: increment if !sign & (G|R|S).
- RMM: increment if G.
- nx = G|R|S, or overflow, or underflow.

**Overflow (e ≥ 2^EXP_W−1).** ovrf=1, nx=1.
- Result is infinity, except in the modes below, which give max finite (exponent all-ones−1, fraction all-ones):
  - RTZ;
  - RDN with a positive result;
  - RUP with a negative result.

**Underflow (e ≤ 0).** Signed zero; udrf=1, nx=1.

**Sticky flags.**
- flags_sticky ORs in {nv,ovrf,udrf,nx} on each output handshake (out_valid & out_ready).
- If clear_flags coincides with a handshake, the clear wins for the old value and that beat's flags are still recorded, i.e. the result equals that beat's flags.

## Timing
**Pipeline.**
- S1: classify, multiply, exponent sum.
- S2: normalise, sticky.
- S3: round, exception, pack.
- Output register = S3.
- Latency: 3 cycles from input handshake to out_valid with out_ready held high.
- Throughput: 1 op per cycle.

**Handshake.**
- Each stage holds a valid bit. A stage loads when it is empty or its contents advance this cycle; bubbles collapse.
- in_ready = !v1 | (stage 1 advances).
- in_ready may depend combinationally on out_ready.
- fp_Z and flags are stable while out_valid & !out_ready.

**flush.**
- Clears all stage valid bits next edge and drops any input beat offered in the same cycle.
- Leaves flags_sticky unchanged.

**Reset (asynchronous, any time, including mid-operation).**
- All valid bits 0, so out_valid=0.
- fp_Z=0, ovrf=udrf=nv=nx=0, flags_sticky=0.
- in_ready=1 after reset deasserts.

**r_mode** is sampled with its operand beat and travels down the pipeline with it.

## Structure
- Package fp_pkg holds:
  - the rounding-mode enum (RNE, RTZ, RDN, RUP, RMM);
  - a function returning the canonical NaN for a given EXP_W/FRC_W;
  - a class enum (ZERO, NORM, INF, NAN);
  - the flag-index constants.
- Sub-module fp_round: purely combinational rounding incrementer taking fraction, G/R/S, sign and mode, and returning the rounded fraction, carry and inexact. It is instantiated in S3.

## Test plan
All values at default parameters.
- 0x40400000 × 0x40400000, RTZ → 0x41100000 after 3 cycles; all flags 0.
- 0x3f800001 × 0x3f800001 → 0x3f800002 in RNE/RTZ/RDN; 0x3f800003 in RUP; nx=1.
- 0x7f000000 × 0x7f000000 → RNE: 0x7f800000, ovrf=nx=1; RTZ: 0x7f7fffff.
- 0x20000000 × 0x1f800000 → 0x00000000 with udrf=nx=1.
- 0x00400000 × 0x40000000 → 0x00000000 with no flags.
- 0x80000000 × 0x7f800000 → 0x7fc00000 with nv=1.
- Stream 8 back-to-back beats with out_ready toggled as 1,0,0,1:
  - results arrive in order with none lost or duplicated;
  - fp_Z is held during stalls;
  - flags_sticky equals the OR of all accepted flags.
- Assert rst_n low mid-stream → out_valid=0 immediately, flags_sticky=0. Repeat the scenario with flush instead of reset → no stale results appear.
